// File: rtl/core_ctrl.sv
// core_ctrl: drives the 34-bit inst bus of core through one weight-stationary tile.
// The sequence is weights xmem->L0->array, then activations xmem->L0->array, then
// OFIFO->pmem. inst, busy and done are all registered.
// Optional build macro: CORE_CTRL_PERF_EN adds the perf_cycles busy-cycle counter.
module core_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] a_base,
  input  logic [addr_bw-1:0] o_base,
  input  logic [cnt_bw-1:0]  n_act,
  input  logic               acc_mode,
  input  logic               ofifo_valid,
  output logic [33:0]        inst,
  output logic               busy,
  output logic               done
`ifdef CORE_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_cycles
`endif
);

  // Field layout: acc, CEN_pmem, WEN_pmem, A_pmem, CEN_xmem, WEN_xmem, A_xmem, strobes.
  // Enables are active-low, so the idle word keeps both SRAMs deselected.
  localparam logic [33:0] IDLE_INST = {1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};

  localparam int RC_MAX = (row > col) ? row : col;
  localparam int RC_W   = $clog2(RC_MAX + 1);
  localparam int CW     = (cnt_bw > RC_W) ? cnt_bw : RC_W;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t ROW_C  = cnt_t'(row);
  localparam cnt_t ROW_M1 = cnt_t'(row - 1);
  localparam cnt_t COL_M1 = cnt_t'(col - 1);
  localparam cnt_t ONE_C  = cnt_t'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_W_L0, S_K_LOAD, S_K_BUBBLE, S_A_L0, S_EXEC, S_DRAIN, S_FIN
  } state_t;

  state_t             state_q, state_d;
  cnt_t               cnt_q, cnt_d;
  logic [cnt_bw-1:0]  wcnt_q, wcnt_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [addr_bw-1:0] w_base_q, w_base_d;
  logic [addr_bw-1:0] a_base_q, a_base_d;
  logic [addr_bw-1:0] o_base_q, o_base_d;
  logic [cnt_bw-1:0]  n_act_q, n_act_d;
  logic               acc_q, acc_d;
  logic [33:0]        inst_q, inst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  cnt_t               n_q_c, n_d_c;

  assign n_q_c = cnt_t'(n_act_q);
  assign n_d_c = cnt_t'(n_act_d);

  // Next state, per-state cycle counter, configuration latch and DRAIN handshake.
  // In DRAIN, cnt counts OFIFO reads (k); a write always follows its read by one cycle,
  // so the tile ends once a write is showing with no read in flight and k == n_act.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    w_base_d = w_base_q;
    a_base_d = a_base_q;
    o_base_d = o_base_q;
    n_act_d  = n_act_q;
    acc_d    = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_base_d = w_base;
          a_base_d = a_base;
          o_base_d = o_base;
          n_act_d  = n_act;
          acc_d    = acc_mode;
          cnt_d    = '0;
          wcnt_d   = '0;
          state_d  = S_W_L0;
        end
      end
      S_W_L0: begin
        if (cnt_q == ROW_C) begin
          cnt_d   = '0;
          state_d = S_K_LOAD;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_K_LOAD: begin
        if (cnt_q == ROW_M1) begin
          cnt_d   = '0;
          state_d = S_K_BUBBLE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_K_BUBBLE: begin
        if (cnt_q == COL_M1) begin
          cnt_d   = '0;
          state_d = (n_act_q == '0) ? S_FIN : S_A_L0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_A_L0: begin
        if (cnt_q == n_q_c) begin
          cnt_d   = '0;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_EXEC: begin
        if (cnt_q == n_q_c - ONE_C) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_DRAIN: begin
        rd_d = ofifo_valid && (cnt_q < n_q_c);
        wr_d = rd_q;
        if (rd_d) cnt_d = cnt_q + ONE_C;
        if (wr_d) wcnt_d = wcnt_q + cnt_bw'(1);
        if (wr_q && !rd_q && (cnt_q == n_q_c)) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decode the instruction word for the upcoming cycle from the next state.
  always_comb begin
    inst_d = IDLE_INST;
    case (state_d)
      S_W_L0: begin
        if (cnt_d < ROW_C) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = w_base_d + addr_bw'(cnt_d);
        end
        if (cnt_d != '0) inst_d[2] = 1'b1;
      end
      S_K_LOAD: begin
        inst_d[0] = 1'b1;
        inst_d[3] = 1'b1;
      end
      S_A_L0: begin
        if (cnt_d < n_d_c) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = a_base_d + addr_bw'(cnt_d);
        end
        if (cnt_d != '0) inst_d[2] = 1'b1;
      end
      S_EXEC: begin
        inst_d[1] = 1'b1;
        inst_d[3] = 1'b1;
      end
      S_DRAIN: begin
        inst_d[6] = rd_d;
        if (wr_d) begin
          inst_d[33]    = acc_d;
          inst_d[32]    = 1'b0;
          inst_d[31]    = 1'b0;
          inst_d[30:20] = o_base_d + addr_bw'(wcnt_q);
        end
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d = (state_d == S_FIN);
  end

  // State, counters, configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      w_base_q <= '0;
      a_base_q <= '0;
      o_base_q <= '0;
      n_act_q  <= '0;
      acc_q    <= 1'b0;
      inst_q   <= IDLE_INST;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      w_base_q <= w_base_d;
      a_base_q <= a_base_d;
      o_base_q <= o_base_d;
      n_act_q  <= n_act_d;
      acc_q    <= acc_d;
      inst_q   <= inst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef CORE_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Busy-cycle counter: cleared by an accepted start, saturating, held after done.
  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_IDLE) && start) perf_d = '0;
    else if (busy_q && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed tiles plus randomized tiles for core_ctrl, checked every cycle
// against a schedule-of-future-cycles model built from the tile rules.
module tb_core_ctrl;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

  typedef struct packed {
    logic        drain;
    logic        done;
    logic        busy;
    logic [33:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, acc_mode = 1'b0, ofifo_valid = 1'b0;
  logic [10:0] w_base = '0, a_base = '0, o_base = '0, n_act = '0;
  logic [33:0] inst;
  logic        busy, done;
`ifdef CORE_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  always #5 clk = ~clk;

  core_ctrl #(.row(ROW), .col(COL), .addr_bw(11), .cnt_bw(11)) dut (
    .clk(clk), .reset(reset), .start(start),
    .w_base(w_base), .a_base(a_base), .o_base(o_base), .n_act(n_act),
    .acc_mode(acc_mode), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done)
`ifdef CORE_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  int n_total = 0, n_pass = 0, cyc = 0;

  // model state
  ent_t        q[$];
  ent_t        cur;
  int          reads, mn;
  logic [10:0] mo;
  logic        macc;
  logic [31:0] perf_m;

  // observations of the DUT for hand-computed checks
  logic [10:0] xrd[$];
  logic [10:0] wra[$];
  logic        wacc[$];
  int          exec_n, done_n, busy_n, rd_n, rd_bad, done_cyc, start_cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  function automatic ent_t mk(input logic b, input logic d, input logic dr);
    ent_t e;
    e.inst  = IDLE_INST;
    e.busy  = b;
    e.done  = d;
    e.drain = dr;
    return e;
  endfunction

  // len SRAM reads from base; L0 write trails each read by one cycle
  task automatic push_fetch(input logic [10:0] base, input int len);
    for (int i = 0; i <= len; i++) begin
      ent_t e = mk(1, 0, 0);
      if (i < len) begin
        e.inst[19]   = 1'b0;
        e.inst[17:7] = base + 11'(i);
      end
      if (i >= 1) e.inst[2] = 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic build_tile();
    ent_t e;
    mn = int'(n_act); mo = o_base; macc = acc_mode; reads = 0;
    push_fetch(w_base, ROW);
    for (int i = 0; i < ROW; i++) begin
      e = mk(1, 0, 0); e.inst[0] = 1'b1; e.inst[3] = 1'b1; q.push_back(e);
    end
    for (int i = 0; i < COL; i++) q.push_back(mk(1, 0, 0));
    if (mn == 0) q.push_back(mk(0, 1, 0));
    else begin
      push_fetch(a_base, mn);
      for (int i = 0; i < mn; i++) begin
        e = mk(1, 0, 0); e.inst[1] = 1'b1; e.inst[3] = 1'b1; q.push_back(e);
      end
      q.push_back(mk(1, 0, 1));
    end
  endtask

  // advance the model across one clock edge using the inputs the bench drove
  task automatic model_edge();
    ent_t e;
    if (reset) begin
      q.delete(); cur = mk(0, 0, 0); reads = 0; perf_m = '0;
      return;
    end
    if (cur.busy && perf_m != 32'hFFFF_FFFF) perf_m = perf_m + 32'd1;
    if (q.size() == 0 && !cur.busy && !cur.done && start) begin
      build_tile();
      perf_m = '0;
    end else if (cur.drain && reads < mn) begin
      if (ofifo_valid) begin
        while (q.size() < 2) q.push_back(mk(1, 0, 1));
        e = q[0]; e.inst[6] = 1'b1; q[0] = e;
        e = q[1]; e.inst[32] = 1'b0; e.inst[31] = 1'b0;
        e.inst[30:20] = mo + 11'(reads); e.inst[33] = macc; q[1] = e;
        reads++;
        if (reads == mn) q.push_back(mk(0, 1, 0));
      end else if (q.size() == 0) q.push_back(mk(1, 0, 1));
    end
    cur = (q.size() != 0) ? q.pop_front() : mk(0, 0, 0);
  endtask

  task automatic compare();
    chk("outputs", 64'({done, busy, inst}), 64'({cur.done, cur.busy, cur.inst}));
`ifdef CORE_CTRL_PERF_EN
    chk("perf_cycles", 64'(perf_cycles), 64'(perf_m));
`endif
    if (!inst[32]) begin wra.push_back(inst[30:20]); wacc.push_back(inst[33]); end
    if (!inst[19]) xrd.push_back(inst[17:7]);
    if (inst[1]) exec_n++;
    if (inst[6]) begin rd_n++; if (!ofifo_valid) rd_bad++; end
    if (done) begin done_n++; done_cyc = cyc; end
    if (busy) busy_n++;
  endtask

  task automatic step(input logic rst, input logic st, input logic ov);
    @(negedge clk);
    reset = rst; start = st; ofifo_valid = ov;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare();
  endtask

  task automatic clear_obs();
    xrd.delete(); wra.delete(); wacc.delete();
    exec_n = 0; done_n = 0; busy_n = 0; rd_n = 0; rd_bad = 0; done_cyc = -1;
  endtask

  function automatic logic ov_pat(input int mode, input int i);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (i % 3) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic scramble();
    w_base = 11'($urandom); a_base = 11'($urandom); o_base = 11'($urandom);
    n_act = 11'($urandom); acc_mode = 1'($urandom);
  endtask

  task automatic run_tile(input logic [10:0] w, input logic [10:0] a, input logic [10:0] o,
                          input logic [10:0] n, input logic acc, input int vmode,
                          input bit inject, input int rst_at);
    bit timed_out = 1;
    clear_obs();
    w_base = w; a_base = a; o_base = o; n_act = n; acc_mode = acc;
    step(0, 1, 1'b0);
    start_cyc = cyc;
    for (int i = 0; i < 400; i++) begin
      logic st;
      if (q.size() == 0 && !cur.busy && !cur.done) begin timed_out = 0; break; end
      if (inject) scramble();
      st = inject && cur.busy && ($urandom_range(0, 9) == 0);
      if (i == rst_at) begin step(1, 0, 0); timed_out = 0; break; end
      step(0, st, ov_pat(vmode, i));
    end
    chk("tile_timeout", 64'(timed_out), 64'd0);
  endtask

  initial begin
    bit found;
    cur = mk(0, 0, 0); perf_m = '0; reads = 0; mn = 0; mo = '0; macc = 1'b0;
    clear_obs();

    // reset state
    repeat (3) step(1, 0, 0);
    chk("reset_inst", 64'(inst), 64'(IDLE_INST));
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    step(0, 0, 0);

    // tile with ofifo_valid tied high
    run_tile(11'd0, 11'd16, 11'd100, 11'd4, 1'b0, 0, 0, -1);
    chk("t1_xrd_count", 64'(xrd.size()), 64'd12);
    for (int i = 0; i < 8; i++) if (i < xrd.size()) chk("t1_w_addr", 64'(xrd[i]), 64'(i));
    for (int i = 0; i < 4; i++) if (8 + i < xrd.size()) chk("t1_a_addr", 64'(xrd[8+i]), 64'(16 + i));
    chk("t1_exec_cycles", 64'(exec_n), 64'd4);
    chk("t1_wr_count", 64'(wra.size()), 64'd4);
    for (int i = 0; i < 4; i++) if (i < wra.size()) chk("t1_pmem_addr", 64'(wra[i]), 64'(100 + i));
    chk("t1_done_count", 64'(done_n), 64'd1);
    chk("t1_busy_cycles", 64'(busy_n), 64'd40);
    step(0, 0, 0);
    chk("t1_busy_after", 64'(busy), 64'd0);
`ifdef CORE_CTRL_PERF_EN
    repeat (3) step(0, 0, 0);
    chk("t1_perf_hold", 64'(perf_cycles), 64'd40);
`endif

    // n_act = 0
    run_tile(11'd5, 11'd9, 11'd7, 11'd0, 1'b1, 0, 0, -1);
    chk("t2_done_latency", 64'(done_cyc - (start_cyc - 1)), 64'(ROW + 1 + ROW + COL + 1));
    chk("t2_no_pmem", 64'(wra.size()), 64'd0);
    chk("t2_no_exec", 64'(exec_n), 64'd0);
    chk("t2_xrd_count", 64'(xrd.size()), 64'd8);

    // DRAIN with ofifo_valid toggling 1,0,0,...
    run_tile(11'd40, 11'd60, 11'd500, 11'd5, 1'b0, 1, 0, -1);
    chk("t3_wr_count", 64'(wra.size()), 64'd5);
    for (int i = 0; i < 5; i++) if (i < wra.size()) chk("t3_pmem_addr", 64'(wra[i]), 64'(500 + i));
    chk("t3_rd_count", 64'(rd_n), 64'd5);
    chk("t3_rd_without_valid", 64'(rd_bad), 64'd0);

    // address wrap with accumulate
    run_tile(11'd2044, 11'd3, 11'd2046, 11'd4, 1'b1, 0, 0, -1);
    chk("t4_wr_count", 64'(wra.size()), 64'd4);
    if (wra.size() == 4) begin
      chk("t4_addr0", 64'(wra[0]), 64'd2046);
      chk("t4_addr1", 64'(wra[1]), 64'd2047);
      chk("t4_addr2", 64'(wra[2]), 64'd0);
      chk("t4_addr3", 64'(wra[3]), 64'd1);
    end
    for (int i = 0; i < wacc.size(); i++) chk("t4_acc", 64'(wacc[i]), 64'd1);
    if (xrd.size() > 4) chk("t4_xmem_wrap", 64'(xrd[4]), 64'd0);

    // start during EXEC ignored, then reset in DRAIN
    clear_obs();
    w_base = 11'd1; a_base = 11'd2; o_base = 11'd3; n_act = 11'd3; acc_mode = 1'b0;
    step(0, 1, 0);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (inst[1]) begin found = 1; break; end
      step(0, 0, 0);
    end
    chk("t5_exec_reached", 64'(found), 64'd1);
    step(0, 1, 0);
    for (int i = 0; i < 100 && !cur.drain; i++) step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t5_busy_in_drain", 64'(busy), 64'd1);
    clear_obs();
    step(1, 0, 0);
    chk("t5_reset_inst", 64'(inst), 64'(IDLE_INST));
    chk("t5_reset_busy", 64'(busy), 64'd0);
    repeat (20) step(0, 0, 0);
    chk("t5_no_done", 64'(done_n), 64'd0);
    chk("t5_stays_idle", 64'(busy_n), 64'd0);

    // randomized tiles
    for (int t = 0; t < 25; t++) begin
      logic [10:0] rw, ra, ro;
      int rst_at;
      rw = ($urandom_range(0, 3) == 0) ? 11'(2040 + $urandom_range(0, 7)) : 11'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 11'(2040 + $urandom_range(0, 7)) : 11'($urandom);
      ro = ($urandom_range(0, 3) == 0) ? 11'(2040 + $urandom_range(0, 7)) : 11'($urandom);
      rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : -1;
      run_tile(rw, ra, ro, 11'($urandom_range(0, 7)), 1'($urandom), 2, 1, rst_at);
      repeat ($urandom_range(0, 3)) step(0, 0, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
